// File: rtl/cpu16_uart_tx_if.sv
// CPU16 system-bus view of the UART transmitter window.
// master: CPU side (drives address/data_in/write, reads data_out/sel).
// slave : peripheral side (decodes the window, returns data_out/sel).
interface cpu16_uart_tx_if;
  localparam int unsigned BUS_W = 16;

  logic [BUS_W-1:0] address;
  logic [BUS_W-1:0] data_in;
  logic             write;
  logic [BUS_W-1:0] data_out;
  logic             sel;

  modport master (
    output address,
    output data_in,
    output write,
    input  data_out,
    input  sel
  );

  modport slave (
    input  address,
    input  data_in,
    input  write,
    output data_out,
    output sel
  );
endinterface

// File: rtl/cpu16_uart_tx.sv
// Memory-mapped 8N1 serial transmitter with a byte FIFO.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-low reset
//   bus   - CPU16 bus slave (address, data_in, write in; data_out, sel out,
//           both combinational from address)
//   txd   - registered serial output, idles high
//   busy  - registered; FIFO non-empty or shifter active
// Register map (word addresses): BASE+0 DATA (write pushes a byte),
// BASE+1 STATUS {8'b0, count, overflow, busy, full, empty} (write clears
// overflow), BASE+2/3 reserved (read 0).
module cpu16_uart_tx #(
  parameter logic [15:0] BASE       = 16'hFF00,
  parameter int unsigned DIVISOR    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  cpu16_uart_tx_if.slave  bus,
  output logic            txd,
  output logic            busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DIV_W = $clog2(DIVISOR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_d;
  logic             busy_d;

  logic             in_win_c, push_req_c, push_c, pop_c, clr_ovf_c;
  logic             empty_c, full_c, tick_c;
  logic [1:0]       offset_c;
  logic [7:0]       status_c;
  logic             unused_c;

  // Address decode: window is the 4-aligned block starting at BASE.
  assign in_win_c   = (bus.address[15:2] == BASE[15:2]);
  assign offset_c   = bus.address[1:0];
  assign push_req_c = bus.write && in_win_c && (offset_c == 2'd0);
  assign clr_ovf_c  = bus.write && in_win_c && (offset_c == 2'd1);
  assign empty_c    = (count_q == '0);
  assign full_c     = (count_q == CNT_W'(FIFO_DEPTH));
  // Full check uses pre-edge state, so a pop on the same edge does not help.
  assign push_c     = push_req_c && !full_c;
  assign tick_c     = (div_q == DIV_W'(DIVISOR - 1));
  assign unused_c   = ^bus.data_in[15:8];

  // Read mux: only STATUS returns data.
  assign status_c     = {4'(count_q), ovf_q, busy, full_c, empty_c};
  assign bus.sel      = in_win_c;
  assign bus.data_out = (in_win_c && (offset_c == 2'd1)) ? {8'h00, status_c} : 16'h0000;

  // FIFO occupancy: simultaneous push and pop leaves count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, count and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      if (push_req_c && full_c) ovf_q <= 1'b1;
      else if (clr_ovf_c)       ovf_q <= 1'b0;
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= bus.data_in[7:0];
  end

  // Shifter state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Shifter next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty_c) state_d = S_START;
      S_START: if (tick_c) state_d = S_DATA;
      S_DATA:  if (tick_c && (bit_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (tick_c) state_d = empty_c ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  // Shifter datapath controls; STOP reloads directly so frames abut.
  always_comb begin
    pop_c   = 1'b0;
    txd_d   = txd;
    shift_d = shift_q;
    bit_d   = bit_q;
    div_d   = tick_c ? '0 : div_q + DIV_W'(1);
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        bit_d = '0;
        txd_d = 1'b1;
        if (!empty_c) begin
          pop_c   = 1'b1;
          shift_d = mem[rd_ptr_q];
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (tick_c) txd_d = shift_q[0];
      end
      S_DATA: begin
        if (tick_c) begin
          if (bit_q == 3'd7) begin
            txd_d = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            txd_d   = shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (tick_c && !empty_c) begin
          pop_c   = 1'b1;
          shift_d = mem[rd_ptr_q];
          bit_d   = '0;
          txd_d   = 1'b0;
        end
      end
      default: begin
        txd_d = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  // Shifter datapath registers; txd returns high asynchronously on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd     <= 1'b1;
      busy    <= 1'b0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd     <= txd_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_cpu16_uart_tx.sv
// Directed bench for cpu16_uart_tx with DIVISOR=4, FIFO_DEPTH=8.
module tb_cpu16_uart_tx;
  localparam logic [15:0] BASE  = 16'hFF00;
  localparam int unsigned DIV   = 4;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic txd;
  logic busy;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  cpu16_uart_tx_if bus ();

  cpu16_uart_tx #(
    .BASE       (BASE),
    .DIVISOR    (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus),
    .txd   (txd),
    .busy  (busy)
  );

  // Expected txd k cycles into a frame (k=1 is the edge that starts it).
  function automatic logic exp_txd(input logic [7:0] b, input int k);
    if (k <= 4)  return 1'b0;
    if (k <= 36) return b[(k - 5) / 4];
    return 1'b1;
  endfunction

  // One bus store; starts and ends at a falling edge.
  task automatic write_word(input logic [15:0] a, input logic [15:0] d);
    bus.address = a;
    bus.data_in = d;
    bus.write   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.write   = 1'b0;
  endtask

  // Follow a frame from cycle k0 to its last stop-bit cycle.
  task automatic expect_frame(input logic [7:0] b, input int k0, input string name);
    for (int k = k0; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (txd !== exp_txd(b, k)) begin
        fails++;
        $display("FAIL %s byte=%h k=%0d txd=%b expected %b", name, b, k, txd, exp_txd(b, k));
      end
    end
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    bus.address = BASE + 16'd1;
    bus.data_in = 16'h0000;
    bus.write   = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (txd !== 1'b1) begin fails++; $display("FAIL reset_txd_in_reset txd=%b expected 1", txd); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.data_out !== 16'h0001) begin fails++; $display("FAIL reset_status got %h expected 0001", bus.data_out); end
    tests++;
    if (txd !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL reset_idle txd=%b busy=%b expected 1 0", txd, busy); end
    tests++;
    if (bus.sel !== 1'b1) begin fails++; $display("FAIL reset_sel_status sel=%b expected 1", bus.sel); end
    bus.address = 16'h1234;
    #1;
    tests++;
    if (bus.sel !== 1'b0 || bus.data_out !== 16'h0000) begin
      fails++; $display("FAIL outside_window sel=%b data=%h expected 0 0000", bus.sel, bus.data_out);
    end
  endtask

  task automatic test_single_frame;
    write_word(BASE, 16'hAB55);
    tests++;
    if (txd !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL single_latency txd=%b busy=%b expected 1 1", txd, busy);
    end
    expect_frame(8'h55, 1, "single_frame");
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_stop busy=%b expected 1", busy); end
    @(posedge clk);
    @(negedge clk);
    bus.address = BASE + 16'd1;
    #1;
    tests++;
    if (busy !== 1'b0 || txd !== 1'b1) begin fails++; $display("FAIL single_busy_drop busy=%b txd=%b expected 0 1", busy, txd); end
    tests++;
    if (bus.data_out !== 16'h0001) begin fails++; $display("FAIL single_status got %h expected 0001", bus.data_out); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    bytes[0] = 8'hA5; bytes[1] = 8'h0F; bytes[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      bus.address = BASE;
      bus.data_in = {8'h00, bytes[i]};
      bus.write   = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    bus.write = 1'b0;
    expect_frame(bytes[0], 3, "b2b_frame0");
    expect_frame(bytes[1], 1, "b2b_frame1");
    expect_frame(bytes[2], 1, "b2b_frame2");
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy_stop busy=%b expected 1", busy); end
    @(posedge clk);
    @(negedge clk);
    bus.address = BASE + 16'd1;
    #1;
    tests++;
    if (busy !== 1'b0 || bus.data_out !== 16'h0001) begin
      fails++; $display("FAIL b2b_done busy=%b status=%h expected 0 0001", busy, bus.data_out);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 10; i++) begin
      bus.address = BASE;
      bus.data_in = 16'h0010 + 16'(i);
      bus.write   = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    bus.write   = 1'b0;
    bus.address = BASE + 16'd1;
    #1;
    tests++;
    if (bus.data_out !== 16'h008E) begin fails++; $display("FAIL ovf_status got %h expected 008E", bus.data_out); end
    write_word(BASE + 16'd1, 16'hFFFF);
    #1;
    tests++;
    if (bus.data_out !== 16'h0086) begin fails++; $display("FAIL ovf_clear got %h expected 0086", bus.data_out); end
    expect_frame(8'h10, 11, "ovf_frame0");
    for (int i = 1; i < 9; i++) expect_frame(8'h10 + 8'(i), 1, "ovf_frame");
    @(posedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || bus.data_out !== 16'h0001) begin
      fails++; $display("FAIL ovf_done busy=%b status=%h expected 0 0001", busy, bus.data_out);
    end
  endtask

  task automatic test_reset_mid_frame;
    int good;
    write_word(BASE, 16'h0000);
    write_word(BASE, 16'h0033);
    repeat (16) begin
      @(posedge clk);
      @(negedge clk);
    end
    tests++;
    if (txd !== 1'b0) begin fails++; $display("FAIL mid_pre_reset txd=%b expected 0", txd); end
    rst_n = 1'b0;
    #1;
    tests++;
    if (txd !== 1'b1) begin fails++; $display("FAIL mid_async_txd txd=%b expected 1", txd); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.address = BASE + 16'd1;
    #1;
    tests++;
    if (bus.data_out !== 16'h0001) begin fails++; $display("FAIL mid_status got %h expected 0001", bus.data_out); end
    good = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (txd === 1'b1 && busy === 1'b0) good++;
    end
    tests++;
    if (good !== 60) begin fails++; $display("FAIL mid_no_resume idle_cycles=%0d expected 60", good); end
  endtask

  task automatic test_decode;
    int good;
    write_word(BASE + 16'd2, 16'h0041);
    write_word(BASE + 16'd3, 16'h0042);
    write_word(16'hFEFF, 16'h0043);
    write_word(16'hFF04, 16'h0044);
    bus.address = BASE + 16'd1;
    #1;
    tests++;
    if (bus.data_out !== 16'h0001) begin fails++; $display("FAIL decode_no_push status=%h expected 0001", bus.data_out); end
    good = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (txd === 1'b1 && busy === 1'b0) good++;
    end
    tests++;
    if (good !== 10) begin fails++; $display("FAIL decode_idle idle_cycles=%0d expected 10", good); end
    for (int i = 0; i < 4; i++) begin
      if (i == 1) continue;
      bus.address = BASE + 16'(i);
      #1;
      tests++;
      if (bus.sel !== 1'b1 || bus.data_out !== 16'h0000) begin
        fails++; $display("FAIL decode_read_%0d sel=%b data=%h expected 1 0000", i, bus.sel, bus.data_out);
      end
    end
    bus.address = 16'hFEFF;
    #1;
    tests++;
    if (bus.sel !== 1'b0 || bus.data_out !== 16'h0000) begin
      fails++; $display("FAIL decode_below sel=%b data=%h expected 0 0000", bus.sel, bus.data_out);
    end
    bus.address = 16'hFF05;
    #1;
    tests++;
    if (bus.sel !== 1'b0 || bus.data_out !== 16'h0000) begin
      fails++; $display("FAIL decode_above sel=%b data=%h expected 0 0000", bus.sel, bus.data_out);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_decode();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
